unary_add_seq: RTL and testbench
================================

# unary_add_seq

Sequencer and collector wrapped around the 5-bit unary adder stage. It accepts two binary operands over a valid/ready handshake and drives the adder's `A`, `B`, `en` and `read_or_write` inputs: first as unary pulse trains, then as a fixed drain window. It counts the adder's `dout` pulses back into a binary sum and captures the adder's one-cycle carry flag `C` as a sticky overflow. Together with the adder it forms a complete binary-in/binary-out unary add path.

## Interface
- `W`, default 5: operand and result width. The adder accumulator is W bits; the unary window length is 2^W.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low. It is shared with the adder so both clear together.
- `start_valid` in 1: operand request.
- `start_ready` out 1: high only in IDLE.
- `op_a` in W: operand A, latched on accept.
- `op_b` in W: operand B, latched on accept.
- `A` out 1: unary stream A, to the adder.
- `B` out 1: unary stream B, to the adder.
- `en` out 1: adder enable.
- `read_or_write` out 1: adder phase select. 0 = accumulate, 1 = drain.
- `c_in` in 1: adder `C`.
- `dout_in` in 1: adder `dout`.
- `res_valid` out 1: one-cycle result strobe.
- `result` out W: (op_a+op_b) mod 2^W.
- `overflow` out 1: op_a+op_b > 2^W-1.

## Operation
- States: IDLE → READ → WRITE → FLUSH → DONE → IDLE.
- IDLE
  - `start_ready`=1.
  - `start_valid`=1 accepts: latch `op_a`/`op_b`, clear the result counter and overflow flag, go to READ.
- READ, exactly 2^W-1 cycles, with read index i=1..2^W-1:
  - `en`=1, `read_or_write`=0.
  - `A`=(i ≤ op_a), `B`=(i ≤ op_b).
- WRITE, exactly 2^W cycles:
  - `en`=1, `read_or_write`=1, `A`=`B`=0.
  - This drains any adder count up to 2^W-1 back to 0.
- FLUSH, 1 cycle:
  - `en`=0, so the adder's `dout` holds its last drain value.
  - This cycle exists only to take the final `dout` sample.
- DONE, 1 cycle:
  - `res_valid`=1.
  - `result` and `overflow` are valid.
  - Returns to IDLE.
- `A`, `B`, `en` and `read_or_write` are registered and change on the same edge as the state, so each state's values are present throughout that state's cycles.
- Delayed flags:
  - `rd_d` is the registered value of (state==READ).
  - `wr_d` is the registered value of (state==WRITE).
- Overflow capture: at each edge where `rd_d`=1, `overflow` |= `c_in`. The flag is sticky because the adder raises `C` only on the wrapping cycle.
- Result capture: at each edge where `wr_d`=1, the W-bit counter is incremented by `dout_in`. This gives exactly 2^W samples (FLUSH included). The maximum count is 2^W-1, so there is no counter wrap.
- `start_valid` outside IDLE is ignored; there is no queueing.
- `result` and `overflow` hold their values until the next accept.

## Timing
- Reset values:
  - state IDLE.
  - `A`=`B`=`en`=`read_or_write`=0.
  - `start_ready`=1.
  - `res_valid`=0, `result`=0, `overflow`=0.
  - `rd_d`=`wr_d`=0.
- Cycle map (W=5), counting the accept edge as edge 0:
  - READ: cycles 1–31.
  - WRITE: cycles 32–63.
  - FLUSH: cycle 64.
  - DONE (`res_valid`): cycle 65.
  - Next accept possible at the end of cycle 66.
- The latency is fixed and independent of operand values. In general it is 2^(W+1)+1 cycles from accept to `res_valid`.
- Boundary cases:
  - op_a=op_b=0: READ still runs its full length with `A`=`B`=0; `result`=0.
  - Wrap: for a+b ≥ 2^W, the adder accumulator wraps. `result`=(a+b) mod 2^W and `overflow`=1.
- Reset mid-operation (any state): return to IDLE with reset values. The adder also clears, so the next operation starts from count 0.

## Test plan
- Reset, then op_a=3, op_b=4 → `start_ready` drops the cycle after accept; `A` high 3 cycles and `B` high 4 cycles; `dout_in` high for 7 cycles; `res_valid` at cycle 65 with `result`=7, `overflow`=0.
- op_a=0, op_b=0 → `A`/`B` never high; `result`=0, `overflow`=0; latency still 65 cycles.
- op_a=31, op_b=0, then op_a=31, op_b=31 back-to-back → first result 31/0; second result 30/1.
- op_a=20, op_b=15 → `c_in` pulses once during READ; `result`=3, `overflow`=1 (sticky through DONE).
- Hold `start_valid`=1 continuously with changing operands → only the value present at each IDLE accept is used; exactly one `res_valid` per 66-cycle pair.
- Assert `rst_n`=0 during WRITE of 10+10, then run 5+6 → all outputs at reset values during reset; second result 11/0.

Source files
------------

// File: rtl/unary_add_seq.sv
// Binary-in/binary-out sequencer around the unary adder stage: emits unary pulse
// trains, drains the accumulator, and counts dout pulses back into a binary sum.
module unary_add_seq #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         A,
    output logic         B,
    output logic         en,
    output logic         read_or_write,
    input  logic         c_in,
    input  logic         dout_in,
    output logic         res_valid,
    output logic [W-1:0] result,
    output logic         overflow
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_FLUSH, S_DONE} state_t;

    localparam logic [W-1:0] CNT_MAX = '1;

    state_t       r_state, w_state_nx;
    logic [W-1:0] r_cnt, w_cnt_nx;
    logic [W-1:0] r_op_a, r_op_b, w_op_a_nx, w_op_b_nx;
    logic         w_accept;
    logic         r_a, r_b, r_en, r_rw, r_res_valid;
    logic         w_a_nx, w_b_nx, w_en_nx, w_rw_nx, w_res_valid_nx;
    logic         r_rd_d, r_wr_d, r_overflow;
    logic [W-1:0] r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_op_a  <= w_op_a_nx;
            r_op_b  <= w_op_b_nx;
        end
    end

    // r_cnt is the read index (1..2^W-1) in READ and the drain index in WRITE.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_valid) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_READ;
                    w_cnt_nx   = W'(1);
                end
            end
            S_READ: begin
                if (r_cnt == CNT_MAX) begin
                    w_state_nx = S_WRITE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx   = r_cnt + W'(1);
                end
            end
            S_WRITE: begin
                if (r_cnt == CNT_MAX) begin
                    w_state_nx = S_FLUSH;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx   = r_cnt + W'(1);
                end
            end
            S_FLUSH: w_state_nx = S_DONE;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        w_op_a_nx = w_accept ? op_a : r_op_a;
        w_op_b_nx = w_accept ? op_b : r_op_b;
    end

    // Adder-side outputs are decoded from the next state so they register on the state edge.
    always_comb begin
        w_a_nx         = (w_state_nx == S_READ) && (w_cnt_nx <= w_op_a_nx);
        w_b_nx         = (w_state_nx == S_READ) && (w_cnt_nx <= w_op_b_nx);
        w_en_nx        = (w_state_nx == S_READ) || (w_state_nx == S_WRITE);
        w_rw_nx        = (w_state_nx == S_WRITE);
        w_res_valid_nx = (w_state_nx == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_en        <= 1'b0;
            r_rw        <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_a         <= w_a_nx;
            r_b         <= w_b_nx;
            r_en        <= w_en_nx;
            r_rw        <= w_rw_nx;
            r_res_valid <= w_res_valid_nx;
        end
    end

    // Adder C and dout lag the phase by one cycle, hence the delayed phase flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_d     <= 1'b0;
            r_wr_d     <= 1'b0;
            r_overflow <= 1'b0;
            r_result   <= '0;
        end else begin
            r_rd_d <= (r_state == S_READ);
            r_wr_d <= (r_state == S_WRITE);
            if (w_accept) begin
                r_overflow <= 1'b0;
                r_result   <= '0;
            end else begin
                if (r_rd_d) r_overflow <= r_overflow | c_in;
                if (r_wr_d) r_result   <= r_result + W'(dout_in);
            end
        end
    end

    assign start_ready   = (r_state == S_IDLE);
    assign A             = r_a;
    assign B             = r_b;
    assign en            = r_en;
    assign read_or_write = r_rw;
    assign res_valid     = r_res_valid;
    assign result        = r_result;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_unary_add_seq.sv
// Bench for unary_add_seq with a behavioural unary adder attached to its adder ports.
module tb_unary_add_seq;

    localparam int W = 5;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         start_ready, A, B, en, read_or_write, res_valid, overflow;
    logic [W-1:0] result;
    logic         c_in, dout_in;

    int n_checks = 0;
    int n_pass   = 0;

    unary_add_seq #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .A(A), .B(B), .en(en), .read_or_write(read_or_write),
        .c_in(c_in), .dout_in(dout_in), .res_valid(res_valid), .result(result),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Unary adder: accumulate A+B with a one-cycle carry on wrap; drain one count per cycle.
    logic [W-1:0] acc;
    logic [W:0]   sum;
    always_comb sum = {1'b0, acc} + (W+1)'(A) + (W+1)'(B);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0; c_in <= 1'b0; dout_in <= 1'b0;
        end else begin
            c_in <= 1'b0;
            if (en) begin
                if (!read_or_write) begin
                    acc     <= sum[W-1:0];
                    c_in    <= sum[W];
                    dout_in <= 1'b0;
                end else if (acc != '0) begin
                    acc     <= acc - W'(1);
                    dout_in <= 1'b1;
                end else begin
                    dout_in <= 1'b0;
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Runs one operation from the current negedge; lat=-1 when res_valid never arrives.
    task automatic run_op(input int a, input int b, output int lat, output int nw,
                          output int drop, output int na, output int nb, output int nd,
                          output int nc, output int nen, output int nrw,
                          output logic [W-1:0] r, output logic ov);
        op_a = W'(a); op_b = W'(b); start_valid = 1'b1;
        nw = 0; lat = -1; drop = 0; na = 0; nb = 0; nd = 0; nc = 0; nen = 0; nrw = 0;
        r = 'x; ov = 1'bx;
        while (!start_ready && nw < 200) begin
            @(negedge clk); nw++;
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) drop = !start_ready;
            na += A; nb += B; nd += dout_in; nc += c_in; nen += en; nrw += read_or_write;
            if (res_valid) begin
                lat = c; r = result; ov = overflow;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({A, B, en, read_or_write, res_valid, overflow, start_ready, result} !== {7'b0000001, 5'b0})
            $display("FAIL reset_vals got=%b exp=%b",
                     {A, B, en, read_or_write, res_valid, overflow, start_ready, result}, {7'b0000001, 5'b0});
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, nw, drop, na, nb, nd, nc, nen, nrw; logic [W-1:0] r; logic ov;
        run_op(3, 4, lat, nw, drop, na, nb, nd, nc, nen, nrw, r, ov);
        n_checks++; if (drop !== 1) $display("FAIL basic_ready_drop got=%0d exp=1", drop); else n_pass++;
        n_checks++; if (na !== 3) $display("FAIL basic_a_pulses got=%0d exp=3", na); else n_pass++;
        n_checks++; if (nb !== 4) $display("FAIL basic_b_pulses got=%0d exp=4", nb); else n_pass++;
        n_checks++; if (nd !== 7) $display("FAIL basic_dout_pulses got=%0d exp=7", nd); else n_pass++;
        n_checks++; if (nen !== 2*N-1) $display("FAIL basic_en_cycles got=%0d exp=%0d", nen, 2*N-1); else n_pass++;
        n_checks++; if (nrw !== N) $display("FAIL basic_rw_cycles got=%0d exp=%0d", nrw, N); else n_pass++;
        n_checks++; if (lat !== 2*N+1) $display("FAIL basic_latency got=%0d exp=%0d", lat, 2*N+1); else n_pass++;
        n_checks++; if ({r, ov} !== {5'd7, 1'b0}) $display("FAIL basic_result got=%0d/%b exp=7/0", r, ov); else n_pass++;
    endtask

    task automatic test_zero();
        int lat, nw, drop, na, nb, nd, nc, nen, nrw; logic [W-1:0] r; logic ov;
        run_op(0, 0, lat, nw, drop, na, nb, nd, nc, nen, nrw, r, ov);
        n_checks++; if (na + nb !== 0) $display("FAIL zero_ab_pulses got=%0d exp=0", na + nb); else n_pass++;
        n_checks++; if (lat !== 2*N+1) $display("FAIL zero_latency got=%0d exp=%0d", lat, 2*N+1); else n_pass++;
        n_checks++; if ({r, ov} !== {5'd0, 1'b0}) $display("FAIL zero_result got=%0d/%b exp=0/0", r, ov); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat, nw, drop, na, nb, nd, nc, nen, nrw; logic [W-1:0] r; logic ov;
        run_op(31, 0, lat, nw, drop, na, nb, nd, nc, nen, nrw, r, ov);
        n_checks++; if ({r, ov} !== {5'd31, 1'b0}) $display("FAIL b2b_first got=%0d/%b exp=31/0", r, ov); else n_pass++;
        run_op(31, 31, lat, nw, drop, na, nb, nd, nc, nen, nrw, r, ov);
        n_checks++; if (nw !== 1) $display("FAIL b2b_accept_gap got=%0d exp=1", nw); else n_pass++;
        n_checks++; if ({r, ov} !== {5'd30, 1'b1}) $display("FAIL b2b_second got=%0d/%b exp=30/1", r, ov); else n_pass++;
    endtask

    task automatic test_wrap();
        int lat, nw, drop, na, nb, nd, nc, nen, nrw; logic [W-1:0] r; logic ov;
        run_op(20, 15, lat, nw, drop, na, nb, nd, nc, nen, nrw, r, ov);
        n_checks++; if (nc !== 1) $display("FAIL wrap_c_pulses got=%0d exp=1", nc); else n_pass++;
        n_checks++; if ({r, ov} !== {5'd3, 1'b1}) $display("FAIL wrap_result got=%0d/%b exp=3/1", r, ov); else n_pass++;
    endtask

    task automatic test_random();
        int lat, nw, drop, na, nb, nd, nc, nen, nrw; logic [W-1:0] r; logic ov;
        int a, b;
        for (int k = 0; k < 8; k++) begin
            a = $urandom_range(0, N-1); b = $urandom_range(0, N-1);
            run_op(a, b, lat, nw, drop, na, nb, nd, nc, nen, nrw, r, ov);
            n_checks++;
            if ({r, ov} !== {W'((a + b) % N), (a + b) > N-1})
                $display("FAIL rand_result a=%0d b=%0d got=%0d/%b exp=%0d/%b", a, b, r, ov, (a + b) % N, (a + b) > N-1);
            else n_pass++;
            n_checks++;
            if ({na, nb, lat} !== {a, b, 2*N+1})
                $display("FAIL rand_shape a=%0d b=%0d got na=%0d nb=%0d lat=%0d", a, b, na, nb, lat);
            else n_pass++;
        end
    endtask

    task automatic test_hold_valid();
        int qa[$], qb[$];
        int a, b, ea, eb, got, last;
        got = 0; last = -1;
        start_valid = 1'b1;
        for (int c = 0; c < 400 && got < 3; c++) begin
            a = $urandom_range(0, N-1); b = $urandom_range(0, N-1);
            if (start_ready) begin qa.push_back(a); qb.push_back(b); end
            op_a = W'(a); op_b = W'(b);
            @(negedge clk);
            if (res_valid) begin
                got++;
                ea = (qa.size() > 0) ? qa.pop_front() : -1;
                eb = (qb.size() > 0) ? qb.pop_front() : -1;
                n_checks++;
                if (ea < 0 || {result, overflow} !== {W'((ea + eb) % N), (ea + eb) > N-1})
                    $display("FAIL hold_result got=%0d/%b exp a=%0d b=%0d", result, overflow, ea, eb);
                else n_pass++;
                if (last >= 0) begin
                    n_checks++;
                    if (c - last !== 2*N+2) $display("FAIL hold_spacing got=%0d exp=%0d", c - last, 2*N+2);
                    else n_pass++;
                end
                last = c;
            end
        end
        start_valid = 1'b0;
        n_checks++;
        if (got !== 3 || qa.size() !== 0) $display("FAIL hold_count got=%0d pending=%0d exp=3/0", got, qa.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, nw, drop, na, nb, nd, nc, nen, nrw, k; logic [W-1:0] r; logic ov;
        op_a = W'(10); op_b = W'(10); start_valid = 1'b1;
        k = 0;
        while (!start_ready && k < 200) begin @(negedge clk); k++; end
        @(posedge clk); #1; start_valid = 1'b0;
        k = 0;
        while (!read_or_write && k < 200) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({A, B, en, read_or_write, res_valid, overflow, start_ready, result} !== {7'b0000001, 5'b0})
            $display("FAIL midreset_vals got=%b exp=%b",
                     {A, B, en, read_or_write, res_valid, overflow, start_ready, result}, {7'b0000001, 5'b0});
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run_op(5, 6, lat, nw, drop, na, nb, nd, nc, nen, nrw, r, ov);
        n_checks++; if ({r, ov} !== {5'd11, 1'b0}) $display("FAIL midreset_next got=%0d/%b exp=11/0", r, ov); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_back_to_back();
        test_wrap();
        test_random();
        test_hold_valid();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
